// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the round-robin divider sequencer
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Index width for n items; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] divzero_q(input int width);
    return ~64'h0 >> (64 - width);
  endfunction

  function automatic logic [63:0] divzero_r(input int width);
    return ~64'h0 >> (64 - width);
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one combinational iteration of a restoring divider
module div_restoring_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] p,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] p_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  always_comb begin
    trial  = {p, bit_in};
    q_bit  = (trial >= {1'b0, divisor});
    // The new partial remainder is below the divisor, so its top bit is always zero.
    p_next = q_bit ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_rr_sequencer.sv
// rtl/div_rr_sequencer.sv - round-robin arbiter and FSM sharing one bit-serial restoring divider
module div_rr_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  rsp_divzero,
  output logic                  busy
);

  localparam int CNT_W = id_w(WIDTH);

  state_t           state, state_next;
  logic [ID_W-1:0]  rr_ptr, grant, owner;
  logic             found, accept, last_iter, zero_div, q_bit;
  logic [WIDTH-1:0] dvd, dsr, quo, prem, prem_next, sel_dvd, sel_dsr;
  logic [CNT_W-1:0] cnt;

  // First valid requester searched upward from the rr pointer, with wrap.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        found = 1'b1;
        grant = ID_W'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[grant] = 1'b1;
  end

  assign accept    = (state == IDLE) && found;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign sel_dvd   = req_dividend[int'(grant)*WIDTH +: WIDTH];
  assign sel_dsr   = req_divisor[int'(grant)*WIDTH +: WIDTH];

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .p       (prem),
    .bit_in  (dvd[WIDTH-1]),
    .divisor (dsr),
    .p_next  (prem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Divide-by-zero passes through RUN for a single cycle to load the all-ones result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (zero_div || last_iter) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      dvd      <= '0;
      dsr      <= '0;
      quo      <= '0;
      prem     <= '0;
      cnt      <= '0;
      zero_div <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dvd      <= sel_dvd;
          dsr      <= sel_dsr;
          owner    <= grant;
          rr_ptr   <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + ID_W'(1);
          quo      <= '0;
          prem     <= '0;
          cnt      <= '0;
          zero_div <= (sel_dsr == '0);
        end
        RUN: if (zero_div) begin
          quo  <= WIDTH'(divzero_q(WIDTH));
          prem <= WIDTH'(divzero_r(WIDTH));
        end else begin
          prem <= prem_next;
          quo  <= {quo[WIDTH-2:0], q_bit};
          dvd  <= {dvd[WIDTH-2:0], 1'b0};
          cnt  <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid     = (state == DONE);
  assign rsp_id        = owner;
  assign rsp_quotient  = quo;
  assign rsp_remainder = prem;
  assign rsp_divzero   = zero_div;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_div_rr_sequencer.sv
// tb/tb_div_rr_sequencer.sv - self-checking bench for div_rr_sequencer
module tb_div_rr_sequencer;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*WIDTH-1:0] req_dividend, req_divisor;
  logic              rsp_valid, rsp_ready, rsp_divzero, busy;
  logic [0:0]        rsp_id;
  logic [WIDTH-1:0]  rsp_quotient, rsp_remainder;

  int n_pass  = 0;
  int n_total = 0;

  div_rr_sequencer #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_divzero(rsp_divzero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Presents one request, waits for its accept and then for rsp_valid; returns latency in edges.
  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b, output int lat);
    int w;
    @(negedge clk);
    req_dividend[id*8 +: 8] = a;
    req_divisor[id*8 +: 8]  = b;
    req_valid[id] = 1'b1;
    w = 0;
    #1;
    while (!req_ready[id] && w < 40) begin @(negedge clk); #1; w++; end
    check("grant", 32'(req_ready[id]), 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    check("ready_after_accept", 32'(req_ready), 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic check_rsp(input string tag, input vec_t v, input int lat);
    check({tag, "_lat"}, lat, v.lat);
    check({tag, "_q"}, 32'(rsp_quotient), 32'(v.q));
    check({tag, "_r"}, 32'(rsp_remainder), 32'(v.r));
    check({tag, "_dz"}, 32'(rsp_divzero), 32'(v.dz));
    check({tag, "_id"}, 32'(rsp_id), v.id);
  endtask

  task automatic retire(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  function automatic vec_t model(input int id, input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    v.id = id; v.a = a; v.b = b;
    if (b == 0) begin v.q = 8'hFF; v.r = 8'hFF; v.dz = 1'b1; v.lat = 1; end
    else begin v.q = a / b; v.r = a % b; v.dz = 1'b0; v.lat = WIDTH; end
    return v;
  endfunction

  vec_t tbl[6];

  initial begin
    int lat, ng, cyc, multi, seen;
    int acc_cyc[4];
    int acc_id[4];
    logic [7:0] sq, sr;
    vec_t v;

    tbl[0] = '{0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 8};
    tbl[1] = '{1, 8'd37,  8'd0,   8'hFF,  8'hFF,  1'b1, 1};
    tbl[2] = '{0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
    tbl[3] = '{1, 8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8};
    tbl[4] = '{0, 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
    tbl[5] = '{1, 8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8};

    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_dividend = '0; req_divisor = '0;
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", 32'(rsp_quotient), 32'd0);
    check("rst_r", 32'(rsp_remainder), 32'd0);
    check("rst_dz", 32'(rsp_divzero), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    req_valid = 2'b11; #1;
    check("rst_ready_both", 32'(req_ready), 32'd1);
    req_valid = 2'b10; #1;
    check("rst_ready_one", 32'(req_ready), 32'd2);
    req_valid = '0;
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].id, tbl[i].a, tbl[i].b, lat);
      check_rsp($sformatf("tbl%0d", i), tbl[i], lat);
      retire($sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      int id;
      logic [7:0] a, b;
      id = int'($urandom_range(0, 1));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      v  = model(id, a, b);
      issue(id, a, b, lat);
      check_rsp($sformatf("rnd%0d", i), v, lat);
      check($sformatf("rnd%0d_inv", i), 32'(v.dz || (rsp_remainder < b &&
            int'(rsp_quotient) * int'(b) + int'(rsp_remainder) == int'(a))), 32'd1);
      retire($sformatf("rnd%0d", i));
    end

    // Fairness with both requesters held valid.
    @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
    req_dividend = {8'd37, 8'd100}; req_divisor = {8'd5, 8'd7};
    req_valid = 2'b11; rsp_ready = 1'b1;
    ng = 0; cyc = 0; multi = 0;
    while (ng < 4 && cyc < 80) begin
      #1;
      if ($countones(req_ready) > 1) multi++;
      if (req_ready != 0) begin
        acc_id[ng] = req_ready[1] ? 1 : 0;
        acc_cyc[ng] = cyc;
        ng++;
      end
      @(negedge clk); cyc++;
    end
    req_valid = '0;
    check("rr_grants", ng, 4);
    check("rr_onehot", multi, 0);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), acc_id[i], i % 2);
    for (int i = 1; i < 4; i++) check($sformatf("rr_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 10);
    cyc = 0;
    while (busy && cyc < 40) begin @(negedge clk); cyc++; end
    check("rr_drain", 32'(busy), 32'd0);

    // Back-pressure in DONE.
    rsp_ready = 1'b0;
    issue(0, 8'd100, 8'd7, lat);
    check("bp_lat", lat, 8);
    sq = rsp_quotient; sr = rsp_remainder;
    req_divisor[15:8] = 8'd3; req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_q", 32'(rsp_quotient), 32'd14);
      check("bp_r", 32'(rsp_remainder), 32'd2);
      check("bp_stable", 32'({rsp_quotient, rsp_remainder}), 32'({sq, sr}));
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid[1] = 1'b0;
    retire("bp");

    // Reset in the middle of RUN, then re-issue.
    @(negedge clk);
    req_dividend[7:0] = 8'd200; req_divisor[7:0] = 8'd9; req_valid[0] = 1'b1;
    #1;
    check("mid_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("mid_valid", 32'(rsp_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_q", 32'(rsp_quotient), 32'd0);
    check("mid_r", 32'(rsp_remainder), 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (rsp_valid || busy) seen++; end
    check("mid_no_rsp", seen, 0);
    issue(0, 8'd200, 8'd9, lat);
    check_rsp("reissue", model(0, 8'd200, 8'd9), lat);
    retire("reissue");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
